// File: rtl/gfsk_zero_demodulator.sv
// GFSK zero-crossing demodulator.
// Turns offset-binary ADC samples of the FSK carrier into a sliced bit stream.
// It detects hysteretic rising crossings and measures the carrier period in
// clock cycles. Each period is sliced to mark/space, a 3-tap majority vote
// smooths the result, and a symbol-timing FSM strobes one bit per symbol.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no trusted carrier; no strobes
// HUNT  | carrier locked; waiting for the first filtered-bit transition
// TRACK | symbol counter running; strobe at 0, resync on transitions
module gfsk_zero_demodulator #(
  parameter int MID           = 128,
  parameter int HYST          = 6,
  parameter int PERIOD_THRESH = 150,
  parameter int PERIOD_MAX    = 1023,
  parameter int SYM_CYCLES    = 2000,
  parameter int LOCK_CNT      = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] ad_data,
  input  logic       ad_valid,
  output logic       data_out,
  output logic       data_valid,
  output logic       carrier_ok,
  output logic [9:0] period
);

  localparam logic [8:0] HI_LVL = 9'(MID + HYST);
  localparam logic [8:0] LO_LVL = 9'(MID - HYST);
  localparam logic [9:0] P_MAX  = 10'(PERIOD_MAX);
  localparam logic [9:0] P_THR  = 10'(PERIOD_THRESH);
  localparam int         SYM_W  = $clog2(SYM_CYCLES);
  localparam logic [SYM_W-1:0] SYM_HALF   = SYM_W'(SYM_CYCLES / 2);
  localparam logic [SYM_W-1:0] SYM_RELOAD = SYM_W'(SYM_CYCLES - 1);
  localparam int         LK_W   = $clog2(LOCK_CNT + 1);
  localparam logic [LK_W-1:0] LOCK_V = LK_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, HUNT, TRACK} state_t;

  logic             sign;
  logic             sign_q;
  logic             rc;
  logic [9:0]       cnt;
  logic             armed;
  logic [LK_W-1:0]  vcnt;
  logic             pv;
  logic             raw;
  logic             sat;
  logic             p_ok;
  logic [2:0]       hist;
  logic [2:0]       hist_nx;
  logic             maj;
  logic             fb;
  logic             fb_tr;
  state_t           state;
  logic [SYM_W-1:0] sym_cnt;

  assign sat     = (cnt == P_MAX);
  assign p_ok    = (cnt >= 10'd2) && (cnt < P_MAX);
  assign hist_nx = {hist[1:0], raw};
  assign maj     = (hist_nx[0] & hist_nx[1]) | (hist_nx[0] & hist_nx[2]) |
                   (hist_nx[1] & hist_nx[2]);

  // comparator sign with hysteresis; only qualified samples move it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sign <= 1'b0;
    end else if (ad_valid) begin
      if ({1'b0, ad_data} >= HI_LVL)      sign <= 1'b1;
      else if ({1'b0, ad_data} <= LO_LVL) sign <= 1'b0;
    end
  end

  // registered rising-crossing pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sign_q <= 1'b0;
      rc     <= 1'b0;
    end else begin
      sign_q <= sign;
      rc     <= sign & ~sign_q;
    end
  end

  // period measurement, validity and carrier lock
  // carrier_ok is cleared only by saturation; a stray invalid period
  // restarts the consecutive count but does not drop an established lock
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      armed      <= 1'b0;
      period     <= '0;
      pv         <= 1'b0;
      raw        <= 1'b0;
      vcnt       <= '0;
      carrier_ok <= 1'b0;
    end else begin
      pv <= 1'b0;
      if (rc) begin
        cnt   <= 10'd1;
        armed <= 1'b1;
        if (armed) begin
          period <= cnt;
          pv     <= p_ok;
          raw    <= (cnt < P_THR);
          if (!p_ok)               vcnt <= '0;
          else if (vcnt != LOCK_V) vcnt <= vcnt + 1'b1;
        end
      end else if (sat) begin
        armed <= 1'b0;
        vcnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (sat)                 carrier_ok <= 1'b0;
      else if (vcnt == LOCK_V) carrier_ok <= 1'b1;
    end
  end

  // 3-tap majority filter over raw bits of valid periods
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist  <= '0;
      fb    <= 1'b0;
      fb_tr <= 1'b0;
    end else begin
      fb_tr <= 1'b0;
      if (pv) begin
        hist  <= hist_nx;
        fb    <= maj;
        fb_tr <= (maj != fb);
      end
    end
  end

  // symbol timing FSM with registered strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (!carrier_ok) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (fb_tr) begin
              sym_cnt <= SYM_HALF;
              state   <= TRACK;
            end
          end
          TRACK: begin
            if (sym_cnt == '0) begin
              data_out   <= fb;
              data_valid <= 1'b1;
              sym_cnt    <= SYM_RELOAD;
            end else begin
              sym_cnt <= sym_cnt - 1'b1;
            end
            // resync wins over the terminal reload; the strobe above still fires
            if (fb_tr) sym_cnt <= SYM_HALF;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gfsk_zero_demodulator.sv
// Directed bench for gfsk_zero_demodulator: square-wave carriers of chosen
// period, symbol segments of 100/200-cycle periods, hand-derived timing.
module tb_gfsk_zero_demodulator;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] ad_data   = 8'd128;
  logic       ad_valid  = 1'b0;
  logic       data_out;
  logic       data_valid;
  logic       carrier_ok;
  logic [9:0] period;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int div   = 1;
  int stb_cyc[$];
  int stb_bit[$];
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic ok_prev = 1'b0;

  gfsk_zero_demodulator dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ad_data    (ad_data),
    .ad_valid   (ad_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .carrier_ok (carrier_ok),
    .period     (period)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // record strobes and carrier_ok edges, sampled away from the active edge
  always @(negedge sys_clk) begin
    if (sys_rst_n && data_valid) begin
      stb_cyc.push_back(cyc);
      stb_bit.push_back(int'(data_out));
    end
    if (carrier_ok && !ok_prev)  rise_cyc = cyc;
    if (!carrier_ok && ok_prev)  fall_cyc = cyc;
    ok_prev = carrier_ok;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge; sample i is presented while cyc = start + i
  task automatic drive_cyc(input int lo, input int hi);
    for (int i = 0; i < lo + hi; i++) begin
      ad_data  = (i < lo) ? 8'd68 : 8'd188;
      ad_valid = ((cyc % div) == 0);
      @(negedge sys_clk);
    end
  endtask

  task automatic drive_per(input int p, input int n);
    repeat (n) drive_cyc(p / 2, p - p / 2);
  endtask

  task automatic drive_bit(input int b);
    if (b != 0) drive_per(100, 20);
    else        drive_per(200, 10);
  endtask

  task automatic park(input int n);
    for (int i = 0; i < n; i++) begin
      ad_data  = 8'd128;
      ad_valid = ((cyc % div) == 0);
      @(negedge sys_clk);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    ad_data   = 8'd128;
    ad_valid  = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stb_cyc.delete();
    stb_bit.delete();
    rise_cyc = -1;
    fall_cyc = -1;
  endtask

  int s;
  int b0;
  int p0;
  int late;
  int bits2[10] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 1};
  int bits6[5]  = '{1, 0, 1, 1, 0};

  initial begin
    // reset state
    repeat (3) @(negedge sys_clk);
    chk_eq("rst_data_out",   data_out,   0);
    chk_eq("rst_data_valid", data_valid, 0);
    chk_eq("rst_carrier_ok", carrier_ok, 0);
    chk_eq("rst_period",     period,     0);
    sys_rst_n = 1'b1;

    // 1: steady 100-cycle carrier -> lock, HUNT, no strobes
    s = cyc;
    drive_per(100, 10);
    chk_eq("t1_period", period, 100);
    chk_eq("t1_carrier_ok", carrier_ok, 1);
    chk_eq("t1_lock_time", (rise_cyc - s >= 453) && (rise_cyc - s <= 455), 1);
    chk_eq("t1_no_strobe", stb_cyc.size(), 0);

    // 2 + 4: symbol recovery, then a lone 300-cycle period inside 1s
    do_reset();
    drive_per(200, 10);
    b0 = cyc;
    for (int k = 0; k < 8; k++) drive_bit(bits2[k]);
    drive_per(100, 9);
    drive_cyc(250, 50);
    drive_per(100, 8);
    drive_bit(1);
    chk_eq("t2_strobe_count", stb_cyc.size(), 10);
    if (stb_cyc.size() == 10) begin
      chk_eq("t2_first_strobe",
             (stb_cyc[0] - b0 >= 1254) && (stb_cyc[0] - b0 <= 1258), 1);
      for (int k = 0; k < 10; k++)
        chk_eq($sformatf("t2_bit%0d", k), stb_bit[k], bits2[k]);
      chk_eq("t2_space_3_4", stb_cyc[3] - stb_cyc[2], 2000);
      chk_eq("t2_space_5_6", stb_cyc[5] - stb_cyc[4], 2000);
      chk_eq("t4_space_8_9", stb_cyc[8] - stb_cyc[7], 2000);
      chk_eq("t4_space_9_10", stb_cyc[9] - stb_cyc[8], 2000);
    end
    chk_eq("t4_data_out_held", data_out, 1);

    // 3: park inside hysteresis -> carrier loss, no further strobes
    p0 = cyc;
    park(3000);
    chk_eq("t3_fall_time", (fall_cyc - p0 >= 975) && (fall_cyc - p0 <= 977), 1);
    chk_eq("t3_carrier_ok", carrier_ok, 0);
    chk_eq("t3_period_held", period, 100);
    chk_eq("t3_no_more_strobes", stb_cyc.size(), 10);
    chk_eq("t3_data_out_held", data_out, 1);

    // 5: reset 500 cycles after a strobe in TRACK
    do_reset();
    drive_per(200, 10);
    drive_per(100, 17);
    drive_cyc(50, 7);
    chk_eq("t5_pre_strobe_count", stb_cyc.size(), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_data_out",   data_out,   0);
    chk_eq("t5_rst_data_valid", data_valid, 0);
    chk_eq("t5_rst_carrier_ok", carrier_ok, 0);
    chk_eq("t5_rst_period",     period,     0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stb_cyc.delete();
    stb_bit.delete();
    drive_per(100, 30);
    chk_eq("t5_relock", carrier_ok, 1);
    chk_eq("t5_no_strobe_without_transition", stb_cyc.size(), 0);
    drive_per(200, 10);
    chk_eq("t5_strobe_after_transition", stb_cyc.size(), 1);
    if (stb_cyc.size() == 1) chk_eq("t5_bit", stb_bit[0], 0);

    // 6: ad_valid 1-in-4
    do_reset();
    div = 4;
    drive_per(200, 10);
    drive_bit(bits6[0]);
    chk_eq("t6_period_a", (period >= 97) && (period <= 103), 1);
    for (int k = 1; k < 4; k++) drive_bit(bits6[k]);
    chk_eq("t6_period_b", (period >= 97) && (period <= 103), 1);
    drive_bit(bits6[4]);
    chk_eq("t6_carrier_ok", carrier_ok, 1);
    chk_eq("t6_strobe_count", stb_cyc.size(), 5);
    late = stb_cyc.size();
    if (late == 5)
      for (int k = 0; k < 5; k++)
        chk_eq($sformatf("t6_bit%0d", k), stb_bit[k], bits6[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
